onehot_step_seq: RTL and testbench

//  Parametrised successor to the processor's 3-bit register/step decoder. Holds a registered

---
 rtl/ctrl_pkg.sv | 10 +
 rtl/dec_onehot.sv | 16 +
 rtl/onehot_step_seq.sv | 76 +++++++
 tb/tb_onehot_step_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control-unit constants: default step-decoder widths and timestep names.
package ctrl_pkg;
  localparam int SEL_W_DEF = 3;
  localparam int N_OUT_DEF = 8;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
endpackage

// File: rtl/dec_onehot.sv
// Enable-gated binary to one-hot decoder; codes at or above N_OUT decode to all-zero.
module dec_onehot #(
  parameter int SEL_W = ctrl_pkg::SEL_W_DEF,
  parameter int N_OUT = ctrl_pkg::N_OUT_DEF
) (
  input  logic             en_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [N_OUT-1:0] y_o
);
  always_comb begin
    y_o = '0;
    for (int i = 0; i < N_OUT; i++) begin
      y_o[i] = en_i && (sel_i == SEL_W'(i));
    end
  end
endmodule

// File: rtl/onehot_step_seq.sv
// Registered step index with load/step/clear, programmable wrap point and one-hot decode.
module onehot_step_seq
  import ctrl_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int N_OUT = N_OUT_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             E,
  input  logic             Clear,
  input  logic             Load,
  input  logic [SEL_W-1:0] W,
  input  logic             Step,
  input  logic [SEL_W-1:0] Last,
  output logic [N_OUT-1:0] Y_out,
  output logic [SEL_W-1:0] Idx,
  output logic             Wrap,
  output logic             Err
);
  // N_OUT may equal 2**SEL_W, so range compares need one extra bit.
  localparam logic [SEL_W:0]   N_EXT    = (SEL_W+1)'(N_OUT);
  localparam logic [SEL_W-1:0] LAST_MAX = SEL_W'(N_OUT - 1);

  logic [SEL_W-1:0] idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [SEL_W-1:0] last_eff;
  logic             w_legal;

  assign last_eff = ({1'b0, Last} >= N_EXT) ? LAST_MAX : Last;
  assign w_legal  = ({1'b0, W} < N_EXT);

  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    err_d  = err_q;
    if (Clear) begin
      idx_d = '0;
      err_d = 1'b0;
    end else if (Load) begin
      if (w_legal) idx_d = W;
      else         err_d = 1'b1;
    end else if (Step) begin
      // An index above a freshly lowered Last wraps just like reaching it.
      if (idx_q >= last_eff) begin
        idx_d  = '0;
        wrap_d = 1'b1;
      end else begin
        idx_d = idx_q + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      idx_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign Idx  = idx_q;
  assign Wrap = wrap_q;
  assign Err  = err_q;

  dec_onehot #(.SEL_W(SEL_W), .N_OUT(N_OUT)) u_dec (
    .en_i  (E),
    .sel_i (idx_q),
    .y_o   (Y_out)
  );
endmodule

// File: tb/tb_onehot_step_seq.sv
// Directed and model-checked bench for onehot_step_seq at N_OUT = 8, 7 and 6.
module tb_onehot_step_seq;
  import ctrl_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset, E, Clear, Load, Step;
  logic [2:0] W, Last;

  logic [7:0] y8;  logic [2:0] i8;  logic wr8, er8;
  logic [6:0] y7;  logic [2:0] i7;  logic wr7, er7;
  logic [5:0] y6;  logic [2:0] i6;  logic wr6, er6;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  onehot_step_seq #(.SEL_W(3), .N_OUT(8)) dut8 (
    .Clock(Clock), .Reset(Reset), .E(E), .Clear(Clear), .Load(Load), .W(W),
    .Step(Step), .Last(Last), .Y_out(y8), .Idx(i8), .Wrap(wr8), .Err(er8));
  onehot_step_seq #(.SEL_W(3), .N_OUT(7)) dut7 (
    .Clock(Clock), .Reset(Reset), .E(E), .Clear(Clear), .Load(Load), .W(W),
    .Step(Step), .Last(Last), .Y_out(y7), .Idx(i7), .Wrap(wr7), .Err(er7));
  onehot_step_seq #(.SEL_W(3), .N_OUT(6)) dut6 (
    .Clock(Clock), .Reset(Reset), .E(E), .Clear(Clear), .Load(Load), .W(W),
    .Step(Step), .Last(Last), .Y_out(y6), .Idx(i6), .Wrap(wr6), .Err(er6));

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference state for the N_OUT=7 instance during the random phase.
  logic [2:0] m_idx;
  logic       m_wrap, m_err;
  logic [2:0] m_last;
  logic [7:0] exp_y;
  logic [2:0] exp_idx [5];
  logic       exp_wr  [5];

  initial begin
    Reset = 1'b1; E = 1'b1; Clear = 1'b0; Load = 1'b0; Step = 1'b0; W = '0; Last = '0;
    tick();
    chk("rst_idx", 32'(i8), 32'(T0));
    chk("rst_y_e1", 32'(y8), 32'h01);
    chk("rst_wrap", 32'(wr8), 32'd0);
    chk("rst_err", 32'(er8), 32'd0);
    chk("rst_y7", 32'(y7), 32'h01);
    E = 1'b0; #1;
    chk("rst_y_e0", 32'(y8), 32'h00);
    E = 1'b1; Reset = 1'b0;

    // Step held with Last=3 wraps after T3.
    exp_idx = '{T1, T2, T3, T0, T1};
    exp_wr  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    Last = 3'd3; Step = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("step_idx%0d", k), 32'(i8), 32'(exp_idx[k]));
      chk($sformatf("step_wrap%0d", k), 32'(wr8), 32'(exp_wr[k]));
      exp_y = 8'd1 << exp_idx[k];
      chk($sformatf("step_y%0d", k), 32'(y8), 32'(exp_y));
    end
    Step = 1'b0;

    // Out-of-range load on N_OUT=7 flags Err and holds Idx (currently 1).
    Load = 1'b1; W = 3'd7;
    tick();
    chk("bad_load_idx7", 32'(i7), 32'd1);
    chk("bad_load_err7", 32'(er7), 32'd1);
    chk("bad_load_idx8", 32'(i8), 32'd7);
    W = 3'd5;
    tick();
    chk("good_load_idx7", 32'(i7), 32'd5);
    chk("good_load_y7", 32'(y7), 32'h20);
    chk("err_sticky7", 32'(er7), 32'd1);
    Load = 1'b0;
    tick();
    chk("hold_err7", 32'(er7), 32'd1);
    chk("hold_idx7", 32'(i7), 32'd5);
    Clear = 1'b1;
    tick();
    chk("clear_idx7", 32'(i7), 32'd0);
    chk("clear_err7", 32'(er7), 32'd0);
    Clear = 1'b0;

    // Load beats Step; Clear beats Load.
    Load = 1'b1; W = 3'd2;
    tick();
    chk("load2", 32'(i8), 32'd2);
    W = 3'd6; Step = 1'b1;
    tick();
    chk("load_over_step", 32'(i8), 32'd6);
    chk("load_no_wrap", 32'(wr8), 32'd0);
    Clear = 1'b1; W = 3'd5;
    tick();
    chk("clear_over_load", 32'(i8), 32'd0);
    Clear = 1'b0; Load = 1'b0; Step = 1'b0;

    // Lowering Last below Idx wraps on the next Step.
    Load = 1'b1; W = 3'd6;
    tick();
    Load = 1'b0; Last = 3'd2; Step = 1'b1;
    tick();
    chk("lowered_last_idx", 32'(i8), 32'd0);
    chk("lowered_last_wrap", 32'(wr8), 32'd1);
    Step = 1'b0; Clear = 1'b1;
    tick();
    chk("clear_wrap", 32'(wr8), 32'd0);
    Clear = 1'b0;

    // Last=7 on N_OUT=6 saturates to 5.
    Last = 3'd7; Step = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("sat_idx%0d", k), 32'(i6), (k == 6) ? 32'd0 : 32'(k));
      chk($sformatf("sat_wrap%0d", k), 32'(wr6), (k == 6) ? 32'd1 : 32'd0);
    end
    chk("sat_idx8", 32'(i8), 32'd6);

    // lastEff=0 makes Wrap pulse on consecutive Steps.
    Last = 3'd0;
    tick();
    chk("l0_idx_a", 32'(i8), 32'd0);
    chk("l0_wrap_a", 32'(wr8), 32'd1);
    tick();
    chk("l0_idx_b", 32'(i8), 32'd0);
    chk("l0_wrap_b", 32'(wr8), 32'd1);

    // E gates the output only; state still advances.
    Last = 3'd7; E = 1'b0;
    tick();
    chk("e0_idx", 32'(i8), 32'd1);
    chk("e0_y", 32'(y8), 32'h00);
    E = 1'b1; #1;
    chk("e1_y", 32'(y8), 32'h02);

    // Reset during a Step: no wrap pulse.
    Reset = 1'b1;
    tick();
    chk("rst_mid_idx", 32'(i8), 32'd0);
    chk("rst_mid_wrap", 32'(wr8), 32'd0);
    Reset = 1'b0; Step = 1'b0;

    // Randomised traffic against a reference model of the N_OUT=7 instance.
    m_idx = 3'd0; m_wrap = 1'b0; m_err = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      Reset = ($urandom_range(63) == 0);
      Clear = ($urandom_range(15) == 0);
      Load  = ($urandom_range(3) == 0);
      Step  = ($urandom_range(1) == 0);
      E     = ($urandom_range(3) != 0);
      W     = 3'($urandom_range(7));
      Last  = 3'($urandom_range(7));
      m_last = (Last >= 3'd7) ? 3'd6 : Last;
      if (Reset) begin
        m_idx = 3'd0; m_wrap = 1'b0; m_err = 1'b0;
      end else if (Clear) begin
        m_idx = 3'd0; m_wrap = 1'b0; m_err = 1'b0;
      end else if (Load) begin
        m_wrap = 1'b0;
        if (W < 3'd7) m_idx = W;
        else          m_err = 1'b1;
      end else if (Step) begin
        if (m_idx >= m_last) begin m_idx = 3'd0; m_wrap = 1'b1; end
        else begin m_idx = m_idx + 3'd1; m_wrap = 1'b0; end
      end else begin
        m_wrap = 1'b0;
      end
      tick();
      exp_y = E ? (8'd1 << m_idx) : 8'd0;
      chk("rnd_idx", 32'(i7), 32'(m_idx));
      chk("rnd_wrap", 32'(wr7), 32'(m_wrap));
      chk("rnd_err", 32'(er7), 32'(m_err));
      chk("rnd_y", 32'(y7), 32'(exp_y[6:0]));
      chk("rnd_onehot0", 32'($onehot0(y8)), 32'd1);
      chk("rnd_y8", 32'(y8), E ? 32'(8'd1 << i8) : 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
